// File: rtl/seg7_decoder_pkg.sv
// Shared definitions for the seven-segment pattern decoder: widths, code map,
// stability-filter state encoding and the pattern-to-nibble decode function.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    // Segment order: bit6=a ... bit1=f, bit0=g, active-high.
    localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h47;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        SETTLE = 1'b0,
        STABLE = 1'b1
    } stab_state_e;

    typedef struct packed {
        logic               hit;
        logic [DIGIT_W-1:0] nibble;
    } seg_decode_t;

    // Map a segment pattern to its hex nibble; hit=0 for blank and illegal codes.
    function automatic seg_decode_t seg_decode(input logic [SEG_W-1:0] pat);
        seg_decode_t r;
        r.hit    = 1'b1;
        r.nibble = '0;
        case (pat)
            SEG_0:   r.nibble = 4'h0;
            SEG_1:   r.nibble = 4'h1;
            SEG_2:   r.nibble = 4'h2;
            SEG_3:   r.nibble = 4'h3;
            SEG_4:   r.nibble = 4'h4;
            SEG_5:   r.nibble = 4'h5;
            SEG_6:   r.nibble = 4'h6;
            SEG_7:   r.nibble = 4'h7;
            SEG_8:   r.nibble = 4'h8;
            SEG_9:   r.nibble = 4'h9;
            SEG_A:   r.nibble = 4'hA;
            SEG_B:   r.nibble = 4'hB;
            SEG_C:   r.nibble = 4'hC;
            SEG_D:   r.nibble = 4'hD;
            SEG_E:   r.nibble = 4'hE;
            SEG_F:   r.nibble = 4'hF;
            default: r.hit    = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder_if.sv
// Decoded-digit valid/ready channel.
//   digit_out   : decoded hex nibble, meaningful while digit_valid=1
//   digit_valid : producer has a digit in its slot
//   digit_ready : consumer takes the digit when valid & ready
interface seg7_decoder_if;
    import seg7_pkg::*;

    logic [DIGIT_W-1:0] digit_out;
    logic               digit_valid;
    logic               digit_ready;

    modport master (output digit_out, output digit_valid, input  digit_ready);
    modport slave  (input  digit_out, input  digit_valid, output digit_ready);
endinterface

// File: rtl/seg7_decoder_stab_filter.sv
// Stability filter: samples the segment bus every cycle and fires a one-cycle
// accept once the sampled pattern has held for STABLE_CYCLES consecutive cycles.
//   clk, rst          : clock, async active-low reset
//   seg_i             : raw segment bus
//   accept_c_o        : combinational accept pulse, registered by the consumer
//   stable_pattern_o  : sampled pattern (valid meaning when accept fires)
module seg7_stab_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg_i,
    output logic             accept_c_o,
    output logic [SEG_W-1:0] stable_pattern_o
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    stab_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEG_W-1:0] s_q;

    // Sample register, counter and state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q     <= '0;
            cnt_q   <= '0;
            state_q <= SETTLE;
        end else begin
            s_q     <= seg_i;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Any change restarts settling; the counter stops at STABLE_CYCLES, so it never wraps.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_c_o = 1'b0;
        if (seg_i != s_q) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
                state_d    = STABLE;
                accept_c_o = 1'b1;
            end
        end
    end

    assign stable_pattern_o = s_q;

endmodule

// File: rtl/seg7_decoder.sv
// Seven-segment pattern decoder: waits for a stable pattern, decodes it to a
// hex nibble and offers it in a single-entry valid/ready slot.
//   clk, rst   : clock, async active-low reset
//   seg_in     : segment bus (bit6=a ... bit0=g)
//   dig        : decoded digit channel (master side)
//   blank      : last accepted pattern was all-off
//   invalid    : sticky, an accepted pattern was not a hex code or blank
//   overrun    : sticky, a digit was dropped because the slot was full
//   clr_flags  : clears invalid/overrun on the next edge (set wins)
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg_in,
    seg7_decoder_if.master   dig,
    output logic             blank,
    output logic             invalid,
    output logic             overrun,
    input  logic             clr_flags
);

    logic               accept_c;
    logic [SEG_W-1:0]   pattern;
    seg_decode_t        dec;

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               blank_q, blank_d;
    logic               invalid_q, invalid_d;
    logic               overrun_q, overrun_d;

    seg7_stab_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk              (clk),
        .rst              (rst),
        .seg_i            (seg_in),
        .accept_c_o       (accept_c),
        .stable_pattern_o (pattern)
    );

    assign dec = seg_decode(pattern);

    // Slot and flag next-state.
    always_comb begin
        logic publish;
        logic consume;
        digit_d   = digit_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        invalid_d = invalid_q;
        overrun_d = overrun_q;
        publish   = accept_c & dec.hit;
        consume   = valid_q & dig.digit_ready;

        if (clr_flags) begin
            invalid_d = 1'b0;
            overrun_d = 1'b0;
        end

        if (accept_c) begin
            blank_d = (pattern == SEG_BLANK);
            if (!dec.hit && pattern != SEG_BLANK) begin
                invalid_d = 1'b1;
            end
        end

        // A publish may reuse a slot that is being drained this same cycle.
        if (publish && (!valid_q || consume)) begin
            digit_d = dec.nibble;
            valid_d = 1'b1;
        end else begin
            if (publish) begin
                overrun_d = 1'b1;
            end
            if (consume) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q   <= '0;
            valid_q   <= 1'b0;
            blank_q   <= 1'b0;
            invalid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            invalid_q <= invalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dig.digit_out   = digit_q;
    assign dig.digit_valid = valid_q;
    assign blank           = blank_q;
    assign invalid         = invalid_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: scoreboard of expected digits plus
// directed checks of flags, latency and reset behaviour.
module tb_seg7_decoder;
    import seg7_pkg::*;

    logic             clk;
    logic             rst;
    logic [SEG_W-1:0] seg_in;
    logic             clr_flags;
    logic             blank, invalid, overrun;
    logic             blank1, invalid1, overrun1;

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;
    int unsigned hs_cnt   = 0;
    logic [3:0]  sb[$];

    seg7_decoder_if bus  ();
    seg7_decoder_if bus1 ();

    seg7_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig       (bus.master),
        .blank     (blank),
        .invalid   (invalid),
        .overrun   (overrun),
        .clr_flags (clr_flags)
    );

    // Minimum-filter instance, used only for the one-cycle latency boundary.
    seg7_decoder #(.STABLE_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig       (bus1.master),
        .blank     (blank1),
        .invalid   (invalid1),
        .overrun   (overrun1),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the oldest expected digit.
    always @(negedge clk) begin
        if (rst && bus.digit_valid && bus.digit_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_digit", 32'(bus.digit_out), 32'hFFFF_FFFF);
            end else begin
                check_eq("sb_digit", 32'(bus.digit_out), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst              = 1'b0;
        seg_in           = SEG_1;
        clr_flags        = 1'b0;
        bus.digit_ready  = 1'b1;
        bus1.digit_ready = 1'b1;
        #12;
        check_eq("rst_valid",   32'(bus.digit_valid), 0);
        check_eq("rst_digit",   32'(bus.digit_out), 0);
        check_eq("rst_flags",   32'({blank, invalid, overrun}), 0);

        // Reset release with '1' held: valid after edge 5 (edge 2 for N=1).
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(4'h1);
        wait_edges(1);
        check_eq("n1_valid_e1", 32'(bus1.digit_valid), 0);
        wait_edges(1);
        check_eq("n1_valid_e2", 32'(bus1.digit_valid), 1);
        check_eq("n1_digit_e2", 32'(bus1.digit_out), 1);
        wait_edges(2);
        check_eq("valid_e4", 32'(bus.digit_valid), 0);
        wait_edges(1);
        check_eq("valid_e5", 32'(bus.digit_valid), 1);
        check_eq("digit_e5", 32'(bus.digit_out), 1);
        wait_edges(1);
        check_eq("valid_e6", 32'(bus.digit_valid), 0);
        wait_edges(20);
        check_eq("single_publish", hs_cnt, 1);

        // Short-lived '2' is filtered; only '3' publishes.
        seg_in = SEG_2;
        wait_edges(2);
        seg_in = SEG_3;
        sb.push_back(4'h3);
        wait_edges(10);
        check_eq("glitch_hs", hs_cnt, 2);

        // Illegal pattern sets invalid, publishes nothing; clr clears it.
        seg_in = 7'h01;
        wait_edges(8);
        check_eq("invalid_set", 32'(invalid), 1);
        check_eq("invalid_novalid", 32'(bus.digit_valid), 0);
        clr_flags = 1'b1;
        wait_edges(1);
        clr_flags = 1'b0;
        check_eq("invalid_clr", 32'(invalid), 0);

        // Full slot: second digit dropped, overrun set, digit held.
        bus.digit_ready = 1'b0;
        seg_in = SEG_7;
        sb.push_back(4'h7);
        wait_edges(8);
        check_eq("hold_valid", 32'(bus.digit_valid), 1);
        check_eq("hold_digit", 32'(bus.digit_out), 7);
        seg_in = SEG_8;
        wait_edges(8);
        check_eq("ovr_digit", 32'(bus.digit_out), 7);
        check_eq("ovr_flag", 32'(overrun), 1);
        bus.digit_ready = 1'b1;
        wait_edges(1);
        check_eq("ovr_drained", 32'(bus.digit_valid), 0);
        check_eq("ovr_hs", hs_cnt, 3);
        clr_flags = 1'b1;
        wait_edges(1);
        clr_flags = 1'b0;
        check_eq("ovr_clr", 32'(overrun), 0);

        // Blank then 'F'.
        seg_in = SEG_BLANK;
        wait_edges(8);
        check_eq("blank_set", 32'(blank), 1);
        check_eq("blank_novalid", 32'(bus.digit_valid), 0);
        seg_in = SEG_F;
        sb.push_back(4'hF);
        wait_edges(8);
        check_eq("blank_clr", 32'(blank), 0);
        check_eq("f_hs", hs_cnt, 4);

        // Async reset with a pending digit and a pattern mid-settle.
        bus.digit_ready = 1'b0;
        seg_in = SEG_4;
        sb.push_back(4'h4);
        wait_edges(8);
        check_eq("pend_valid", 32'(bus.digit_valid), 1);
        seg_in = SEG_5;
        wait_edges(2);
        rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.digit_valid), 0);
        check_eq("arst_digit", 32'(bus.digit_out), 0);
        check_eq("arst_flags", 32'({blank, invalid, overrun}), 0);
        sb.delete();
        #2;
        rst = 1'b1;
        bus.digit_ready = 1'b1;
        sb.push_back(4'h5);
        wait_edges(4);
        check_eq("rerun_e4", 32'(bus.digit_valid), 0);
        wait_edges(1);
        check_eq("rerun_e5", 32'(bus.digit_valid), 1);
        check_eq("rerun_digit", 32'(bus.digit_out), 5);
        wait_edges(3);
        check_eq("final_hs", hs_cnt, 5);
        check_eq("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
